// File: rtl/neopixel_frame_scheduler.sv
// neopixel_frame_scheduler: double-buffered colour store that replays the
// committed frame into a NeoPixel strand controller, issues send, waits for
// serial transmission and then holds the WS2812 latch gap.
module neopixel_frame_scheduler #(
  parameter int NUM_PIXELS     = 5,
  parameter int LATCH_CYCLES   = 2500,
  parameter int REFRESH_CYCLES = 833334,
  parameter int TX_TIMEOUT     = 8192
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_pixel,
  input  logic [1:0] wr_color,
  input  logic [7:0] wr_level,
  input  logic       commit,
  input  logic       auto_refresh_en,
  output logic       busy,
  output logic       frame_done,
  output logic       tx_error,
  output logic       strand_load_color,
  output logic [1:0] strand_color_index,
  output logic [2:0] strand_pixel_index,
  output logic [7:0] strand_color_level,
  output logic       strand_send_it,
  input  logic       strand_ready_to_load,
  input  logic       strand_ready_to_send
);

  localparam int CMAX = (LATCH_CYCLES > TX_TIMEOUT) ? LATCH_CYCLES : TX_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [3:0]    NP    = 4'(NUM_PIXELS);
  localparam logic [2:0]    LASTP = 3'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] LMAX  = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] TMAX  = CW'(TX_TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX  = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_LATCH
  } state_t;

  state_t state_q;

  logic [NUM_PIXELS-1:0][2:0][7:0] back_q, back_d, front_q;
  logic          commit_pending_q, refresh_pending_q;
  logic [RW-1:0] refresh_q;
  logic [2:0]    pix_q;
  logic [1:0]    col_q;
  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          tx_error_q;

  logic wr_ok, launch, last_load, refresh_hit, in_load;

  assign wr_ok       = wr_en && ({1'b0, wr_pixel} < NP) && (wr_color != 2'b11);
  assign launch      = (state_q == S_IDLE) && (commit_pending_q || refresh_pending_q)
                       && strand_ready_to_load;
  assign last_load   = (pix_q == LASTP) && (col_q == 2'd2);
  assign refresh_hit = auto_refresh_en && (refresh_q == RMAX);
  assign in_load     = (state_q == S_LOAD);

  // Back buffer with this cycle's write merged, so a same-edge write lands in the snapshot
  always_comb begin
    back_d = back_q;
    if (wr_ok) back_d[wr_pixel][wr_color] = wr_level;
  end

  // Host side: back buffer, pending flags and refresh timer (a new event beats the launch clear)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      back_q            <= '0;
      commit_pending_q  <= 1'b0;
      refresh_pending_q <= 1'b0;
      refresh_q         <= '0;
    end else begin
      back_q <= back_d;
      if (commit)      commit_pending_q <= 1'b1;
      else if (launch) commit_pending_q <= 1'b0;
      if (refresh_hit) refresh_pending_q <= 1'b1;
      else if (launch) refresh_pending_q <= 1'b0;
      if (!auto_refresh_en || refresh_q == RMAX) refresh_q <= '0;
      else                                       refresh_q <= refresh_q + RW'(1);
    end
  end

  // Frame sequencer: snapshot, load walk, send, transmit wait with timeout, latch gap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      tx_error_q <= 1'b0;
      front_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q <= S_LOAD;
            pix_q   <= '0;
            col_q   <= '0;
            if (commit_pending_q) front_q <= back_d;
          end
        end
        S_LOAD: begin
          if (strand_ready_to_load) begin
            if (last_load) begin
              state_q <= S_SEND;
              pix_q   <= '0;
              col_q   <= '0;
            end else if (col_q == 2'd2) begin
              col_q <= '0;
              pix_q <= pix_q + 3'd1;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end
        end
        S_SEND: begin
          if (strand_ready_to_send) begin
            state_q <= S_WAIT_TX;
            cnt_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        S_WAIT_TX: begin
          if (phase_q && strand_ready_to_send) begin
            state_q <= S_LATCH;
            cnt_q   <= '0;
          end else if (cnt_q == TMAX) begin
            tx_error_q <= 1'b1;
            state_q    <= S_LATCH;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (!strand_ready_to_send) phase_q <= 1'b1;
          end
        end
        S_LATCH: begin
          if (cnt_q == LMAX) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy               = (state_q != S_IDLE);
  assign frame_done         = (state_q == S_LATCH) && (cnt_q == LMAX);
  assign tx_error           = tx_error_q;
  assign strand_load_color  = in_load && strand_ready_to_load;
  assign strand_color_index = in_load ? col_q : '0;
  assign strand_pixel_index = in_load ? pix_q : '0;
  assign strand_color_level = in_load ? front_q[pix_q][col_q] : '0;
  assign strand_send_it     = (state_q == S_SEND) && strand_ready_to_send;

endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
// Bench for neopixel_frame_scheduler: strand-controller model, load monitor
// and a frame-store reference model driven by random and directed writes.
module tb_neopixel_frame_scheduler;

  localparam int NP = 5;
  localparam int LC = 20;
  localparam int RC = 1000;
  localparam int TT = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_pixel = '0;
  logic [1:0] wr_color = '0;
  logic [7:0] wr_level = '0;
  logic       commit = 1'b0;
  logic       auto_refresh_en = 1'b0;
  logic       strand_ready_to_load = 1'b1;
  logic       strand_ready_to_send = 1'b1;
  logic       busy, frame_done, tx_error, strand_load_color, strand_send_it;
  logic [1:0] strand_color_index;
  logic [2:0] strand_pixel_index;
  logic [7:0] strand_color_level;

  neopixel_frame_scheduler #(
    .NUM_PIXELS(NP), .LATCH_CYCLES(LC), .REFRESH_CYCLES(RC), .TX_TIMEOUT(TT)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_pixel(wr_pixel),
    .wr_color(wr_color), .wr_level(wr_level), .commit(commit),
    .auto_refresh_en(auto_refresh_en), .busy(busy), .frame_done(frame_done),
    .tx_error(tx_error), .strand_load_color(strand_load_color),
    .strand_color_index(strand_color_index), .strand_pixel_index(strand_pixel_index),
    .strand_color_level(strand_color_level), .strand_send_it(strand_send_it),
    .strand_ready_to_load(strand_ready_to_load), .strand_ready_to_send(strand_ready_to_send)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] p;
    logic [1:0] c;
    logic [7:0] l;
    int         cyc;
  } ld_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  ld_t ld_q[$];
  int  send_cnt = 0, send_cyc = 0, done_cnt = 0, done_cyc = 0, rise_cyc = 0;
  bit  tx_hang = 1'b0;
  int  tx_len = 8;
  int  m_last = 0, m_cnt = 0;
  int  c0 = 0;

  // Reference frame store: what the host wrote, and what the last snapshot froze
  logic [7:0] back_m [NP][3];
  logic [7:0] front_m[NP][3];
  bit         cpend = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every load accepted on the following edge, plus send and done events
  always @(negedge clock) begin
    if (strand_load_color)
      ld_q.push_back('{strand_pixel_index, strand_color_index, strand_color_level, cyc});
    if (strand_send_it) begin
      send_cnt = send_cnt + 1;
      send_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Strand controller: drops ready_to_send for tx_len cycles after each send_it
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (send_cnt != m_last) begin
        m_last = send_cnt;
        if (!tx_hang) begin
          strand_ready_to_send = 1'b0;
          m_cnt = tx_len;
        end
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          strand_ready_to_send = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++) begin
        back_m[p][c]  = 8'h00;
        front_m[p][c] = 8'h00;
      end
    cpend = 1'b0;
  endfunction

  function automatic void model_launch();
    if (cpend) front_m = back_m;
    cpend = 1'b0;
  endfunction

  // All tasks start and end 1 time unit after a rising edge
  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    commit = 1'b0;
    auto_refresh_en = 1'b0;
    strand_ready_to_load = 1'b1;
    tx_hang = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    ld_q.delete();
  endtask

  task automatic do_write(input int p, input int c, input int l);
    wr_en = 1'b1;
    wr_pixel = 3'(p);
    wr_color = 2'(c);
    wr_level = 8'(l);
    if (p < NP && c != 3) back_m[p][c] = 8'(l);
    @(posedge clock);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    c0 = cyc;
    cpend = 1'b1;
    @(posedge clock);
    #1;
    commit = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock);
      if (done_cnt != start) ok = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || tx_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b err=%b exp 0 0 0", busy, frame_done, tx_error);
    end
    checks++;
    if ({strand_load_color, strand_color_index, strand_pixel_index, strand_color_level, strand_send_it} !== '0) begin
      errors++;
      $display("FAIL reset_strand got ld=%b ci=%0d pi=%0d lv=%02h send=%b exp all 0",
               strand_load_color, strand_color_index, strand_pixel_index, strand_color_level, strand_send_it);
    end
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || ld_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b loads=%0d exp 0 0", busy, ld_q.size());
    end
  endtask

  task automatic test_basic();
    bit ok;
    int s0;
    ld_t fr[$];
    ld_q.delete();
    s0 = send_cnt;
    do_write(2, 2, 8'hA5);
    do_commit();
    model_launch();
    wait_done(400, ok);
    fr = ld_q;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done got timeout exp frame_done"); end
    checks++;
    if (fr.size() == 0 || fr[0].cyc - c0 < 1 || fr[0].cyc - c0 > 2) begin
      errors++;
      $display("FAIL basic_latency got loads=%0d dly=%0d exp 1..2", fr.size(), fr.size() ? fr[0].cyc - c0 : -1);
    end
    checks++;
    if (fr.size() != 3 * NP) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", fr.size(), 3 * NP); end
    for (int i = 0; i < fr.size() && i < 3 * NP; i++) begin
      checks++;
      if (fr[i].p !== 3'(i / 3) || fr[i].c !== 2'(i % 3) || fr[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL basic_load[%0d] got p%0d c%0d %02h exp p%0d c%0d %02h",
                 i, fr[i].p, fr[i].c, fr[i].l, i / 3, i % 3, front_m[i / 3][i % 3]);
      end
    end
    checks++;
    if (front_m[2][2] !== 8'hA5 || send_cnt - s0 != 1) begin
      errors++;
      $display("FAIL basic_send got sends=%0d exp 1", send_cnt - s0);
    end
    checks++;
    if (done_cyc - rise_cyc != LC) begin
      errors++;
      $display("FAIL basic_latch got=%0d exp=%0d", done_cyc - rise_cyc, LC);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_invalid();
    bit ok;
    ld_t fr[$];
    do_reset();
    do_write(5, 0, 8'hFF);
    do_write(0, 3, 8'h33);
    do_commit();
    model_launch();
    wait_done(400, ok);
    fr = ld_q;
    checks++;
    if (!ok || fr.size() != 3 * NP) begin
      errors++;
      $display("FAIL invalid_count got ok=%0d loads=%0d exp 1 %0d", ok, fr.size(), 3 * NP);
    end
    for (int i = 0; i < fr.size() && i < 3 * NP; i++) begin
      checks++;
      if (fr[i].l !== 8'h00 || fr[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL invalid_load[%0d] got %02h exp 00", i, fr[i].l);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    ld_t fr[$];
    for (int it = 0; it < 3; it++) begin
      ld_q.delete();
      for (int w = 0; w < 12; w++)
        do_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
      do_commit();
      model_launch();
      wait_done(400, ok);
      fr = ld_q;
      checks++;
      if (!ok || fr.size() != 3 * NP) begin
        errors++;
        $display("FAIL random%0d_count got ok=%0d loads=%0d exp 1 %0d", it, ok, fr.size(), 3 * NP);
      end
      for (int i = 0; i < fr.size() && i < 3 * NP; i++) begin
        checks++;
        if (fr[i].p !== 3'(i / 3) || fr[i].c !== 2'(i % 3) || fr[i].l !== front_m[i / 3][i % 3]) begin
          errors++;
          $display("FAIL random%0d_load[%0d] got p%0d c%0d %02h exp p%0d c%0d %02h",
                   it, i, fr[i].p, fr[i].c, fr[i].l, i / 3, i % 3, front_m[i / 3][i % 3]);
        end
      end
    end
  endtask

  task automatic test_busy_commit();
    bit ok, seen;
    int s0, d0, d1;
    ld_t fr1[$], fr2[$];
    tx_len = 30;
    ld_q.delete();
    do_write($urandom_range(0, NP - 1), $urandom_range(0, 2), $urandom_range(0, 255));
    do_commit();
    model_launch();
    s0 = send_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock);
      if (send_cnt != s0) seen = 1'b1;
    end
    #1;
    checks++;
    if (!seen) begin errors++; $display("FAIL busy_send got timeout exp send_it"); end
    do_write(0, 0, 8'h10);
    do_commit();
    do_commit();
    wait_done(400, ok);
    d0 = done_cyc;
    fr1 = ld_q;
    ld_q.delete();
    checks++;
    if (!ok || fr1.size() != 3 * NP) begin
      errors++;
      $display("FAIL busy_frame1_count got ok=%0d loads=%0d exp 1 %0d", ok, fr1.size(), 3 * NP);
    end
    for (int i = 0; i < fr1.size() && i < 3 * NP; i++) begin
      checks++;
      if (fr1[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL busy_frame1[%0d] got %02h exp %02h", i, fr1[i].l, front_m[i / 3][i % 3]);
      end
    end
    model_launch();
    wait_done(400, ok);
    fr2 = ld_q;
    ld_q.delete();
    d1 = done_cnt;
    checks++;
    if (!ok || fr2.size() != 3 * NP || fr2[0].cyc != d0 + 2) begin
      errors++;
      $display("FAIL busy_frame2_start got ok=%0d loads=%0d start=%0d exp start=%0d",
               ok, fr2.size(), fr2.size() ? fr2[0].cyc : -1, d0 + 2);
    end
    for (int i = 0; i < fr2.size() && i < 3 * NP; i++) begin
      checks++;
      if (fr2[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL busy_frame2[%0d] got %02h exp %02h", i, fr2[i].l, front_m[i / 3][i % 3]);
      end
    end
    checks++;
    if (front_m[0][0] !== 8'h10 || (fr2.size() > 0 && fr2[0].l !== 8'h10)) begin
      errors++;
      $display("FAIL busy_p0red got %02h exp 10", fr2.size() ? fr2[0].l : 8'h00);
    end
    repeat (200) @(posedge clock);
    #1;
    checks++;
    if (ld_q.size() != 0 || done_cnt != d1) begin
      errors++;
      $display("FAIL busy_extra got loads=%0d frames=%0d exp 0 0", ld_q.size(), done_cnt - d1);
    end
    tx_len = 8;
  endtask

  task automatic test_auto_refresh();
    bit ok;
    ld_t fr1[$], fr2[$];
    for (int w = 0; w < 6; w++)
      do_write($urandom_range(0, NP - 1), $urandom_range(0, 2), $urandom_range(0, 255));
    ld_q.delete();
    auto_refresh_en = 1'b1;
    wait_done(1300, ok);
    fr1 = ld_q;
    ld_q.delete();
    checks++;
    if (!ok) begin errors++; $display("FAIL auto_frame1 got timeout exp frame"); end
    wait_done(1300, ok);
    fr2 = ld_q;
    ld_q.delete();
    auto_refresh_en = 1'b0;
    checks++;
    if (!ok || fr1.size() != 3 * NP || fr2.size() != 3 * NP) begin
      errors++;
      $display("FAIL auto_count got ok=%0d loads=%0d,%0d exp %0d", ok, fr1.size(), fr2.size(), 3 * NP);
    end
    checks++;
    if (fr1.size() > 0 && fr2.size() > 0 && fr2[0].cyc - fr1[0].cyc != RC) begin
      errors++;
      $display("FAIL auto_period got=%0d exp=%0d", fr2[0].cyc - fr1[0].cyc, RC);
    end
    for (int i = 0; i < fr1.size() && i < 3 * NP && i < fr2.size(); i++) begin
      checks++;
      if (fr1[i].l !== front_m[i / 3][i % 3] || fr2[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL auto_load[%0d] got %02h,%02h exp %02h", i, fr1[i].l, fr2[i].l, front_m[i / 3][i % 3]);
      end
    end
    repeat (1100) @(posedge clock);
    #1;
    checks++;
    if (ld_q.size() != 0) begin
      errors++;
      $display("FAIL auto_disabled got loads=%0d exp 0", ld_q.size());
    end
  endtask

  task automatic test_stall();
    bit ok, seen;
    int k;
    ld_t fr[$];
    ld_q.delete();
    do_commit();
    model_launch();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock);
      if (ld_q.size() >= 7) seen = 1'b1;
    end
    #1;
    strand_ready_to_load = 1'b0;
    k = ld_q.size();
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_reach got timeout exp 7 loads"); end
    for (int s = 0; s < 4; s++) begin
      @(negedge clock);
      checks++;
      if (strand_load_color !== 1'b0 || strand_pixel_index !== 3'(k / 3) || strand_color_index !== 2'(k % 3)) begin
        errors++;
        $display("FAIL stall_hold[%0d] got ld=%b p%0d c%0d exp ld=0 p%0d c%0d",
                 s, strand_load_color, strand_pixel_index, strand_color_index, k / 3, k % 3);
      end
    end
    @(posedge clock);
    #1;
    strand_ready_to_load = 1'b1;
    checks++;
    if (ld_q.size() != k) begin errors++; $display("FAIL stall_noload got=%0d exp=%0d", ld_q.size(), k); end
    wait_done(400, ok);
    fr = ld_q;
    checks++;
    if (!ok || fr.size() != 3 * NP) begin
      errors++;
      $display("FAIL stall_count got ok=%0d loads=%0d exp 1 %0d", ok, fr.size(), 3 * NP);
    end
    for (int i = 0; i < fr.size() && i < 3 * NP; i++) begin
      checks++;
      if (fr[i].p !== 3'(i / 3) || fr[i].c !== 2'(i % 3) || fr[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL stall_load[%0d] got p%0d c%0d %02h exp p%0d c%0d %02h",
                 i, fr[i].p, fr[i].c, fr[i].l, i / 3, i % 3, front_m[i / 3][i % 3]);
      end
    end
  endtask

  task automatic test_timeout_and_reset();
    bit ok, seen;
    int s0, ecyc;
    ld_t fr[$];
    tx_hang = 1'b1;
    ld_q.delete();
    do_commit();
    model_launch();
    s0 = send_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock);
      if (send_cnt != s0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_send got timeout exp send_it"); end
    seen = 1'b0;
    ecyc = -1;
    for (int i = 0; i < TT + 20 && !seen; i++) begin
      @(negedge clock);
      if (tx_error === 1'b1) begin seen = 1'b1; ecyc = cyc; end
    end
    checks++;
    if (!seen || ecyc - send_cyc < TT || ecyc - send_cyc > TT + 1) begin
      errors++;
      $display("FAIL timeout_delay got seen=%0d dly=%0d exp %0d..%0d", seen, ecyc - send_cyc, TT, TT + 1);
    end
    @(posedge clock);
    #1;
    wait_done(LC + 10, ok);
    fr = ld_q;
    checks++;
    if (!ok || tx_error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_latch got done=%0d err=%b busy=%b exp 1 1 0", ok, tx_error, busy);
    end
    checks++;
    if (fr.size() != 3 * NP) begin errors++; $display("FAIL timeout_count got=%0d exp=%0d", fr.size(), 3 * NP); end
    tx_hang = 1'b0;
    ld_q.delete();
    do_write(1, 1, 8'h5A);
    do_commit();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock);
      if (ld_q.size() >= 5) seen = 1'b1;
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (!seen || busy !== 1'b0 || tx_error !== 1'b0 || frame_done !== 1'b0 ||
        {strand_load_color, strand_color_index, strand_pixel_index, strand_color_level, strand_send_it} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b err=%b ld=%b ci=%0d pi=%0d lv=%02h send=%b exp all 0",
               busy, tx_error, strand_load_color, strand_color_index, strand_pixel_index,
               strand_color_level, strand_send_it);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    ld_q.delete();
    repeat (30) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || ld_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got busy=%b loads=%0d exp 0 0", busy, ld_q.size());
    end
    do_commit();
    model_launch();
    wait_done(400, ok);
    fr = ld_q;
    checks++;
    if (!ok || fr.size() != 3 * NP) begin
      errors++;
      $display("FAIL reset_frame_count got ok=%0d loads=%0d exp 1 %0d", ok, fr.size(), 3 * NP);
    end
    for (int i = 0; i < fr.size() && i < 3 * NP; i++) begin
      checks++;
      if (fr[i].l !== front_m[i / 3][i % 3]) begin
        errors++;
        $display("FAIL reset_frame[%0d] got %02h exp %02h", i, fr[i].l, front_m[i / 3][i % 3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_random();
    test_busy_commit();
    test_auto_refresh();
    test_stall();
    test_timeout_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_scheduler.md
Name: neopixel_frame_scheduler

Overview:
Sequences the NeoPixel strand controller for one complete frame refresh. The host writes colour bytes into a double-buffered frame store. The scheduler replays the committed frame into the strand controller's load port, issues send, waits for serial transmission to finish, and then enforces the WS2812 latch gap. It sits between host/CPU logic and the strand controller, and supports commit-driven and periodic auto-refresh updates.

Parameters:
NUM_PIXELS, 5, pixels in strand (1..8); pixel index width fixed at 3
LATCH_CYCLES, 2500, low-time after frame (50 us at 50 MHz)
REFRESH_CYCLES, 833334, auto-refresh period in clocks (~60 Hz)
TX_TIMEOUT, 8192, max clocks in WAIT_TX before error

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write one colour byte into back buffer
wr_pixel  in  3  pixel index of write
wr_color  in  2  00=red, 01=blue, 10=green; 11 is invalid
wr_level  in  8  colour level
commit  in  1  pulse: back buffer becomes pending frame
auto_refresh_en  in  1  enable periodic resend of front buffer
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of LATCH
tx_error  out  1  sticky; set on WAIT_TX timeout; cleared only by reset
strand_load_color  out  1  to strand load_color
strand_color_index  out  2  to strand color_index
strand_pixel_index  out  3  to strand pixel_index
strand_color_level  out  8  to strand color_level
strand_send_it  out  1  to strand send_it
strand_ready_to_load  in  1  from strand
strand_ready_to_send  in  1  from strand

Behaviour:
- Reset: all outputs 0, both buffers 0, all pending flags and counters 0, state IDLE. Reset is asynchronous, so strand_* outputs deassert immediately even mid-frame.
- Writes: a write with wr_pixel >= NUM_PIXELS or wr_color == 11 is ignored. Otherwise the byte goes to the back buffer on the same edge, in any state.
- commit sets commit_pending. A commit while already pending is absorbed.
- Refresh timer: counts only while auto_refresh_en=1. It clears and holds 0 when auto_refresh_en=0. At REFRESH_CYCLES-1 it sets refresh_pending and wraps to 0.
- States: IDLE, LOAD, SEND, WAIT_TX, LATCH.
- IDLE -> LOAD when (commit_pending | refresh_pending) & strand_ready_to_load.
  - On that edge: if commit_pending, the back buffer is copied to the front buffer.
  - Both pending flags clear on that edge.
  - Writes up to and including that edge are in the snapshot.
  - commit and refresh pending together produce a single frame.
- LOAD: walks pixel 0..NUM_PIXELS-1; within each pixel the colour order is red(00), blue(01), green(10).
  - One load per cycle from the front buffer: 3*NUM_PIXELS cycles when unstalled.
  - strand_load_color=1 only while in LOAD and strand_ready_to_load=1. When ready_to_load=0 the walk holds.
  - The last load is followed by SEND.
- SEND: when strand_ready_to_send=1, assert strand_send_it for exactly one cycle, then go to WAIT_TX.
- WAIT_TX, phase 1: wait for strand_ready_to_send=0.
- WAIT_TX, phase 2: wait for strand_ready_to_send=1, then go to LATCH.
- WAIT_TX timeout: the timer starts on entry. When it reaches TX_TIMEOUT, set tx_error and go to LATCH.
- LATCH: count LATCH_CYCLES clocks with all strand_* outputs 0. In the final cycle pulse frame_done, then go to IDLE.
- Events arriving while busy: commit or refresh expiry only sets pending. The frame starts in the first IDLE cycle after frame_done (IDLE dwell of 1 cycle).
- Strand outputs in non-LOAD states:
  - strand_color_index, strand_pixel_index and strand_color_level are 0 outside LOAD.
  - strand_send_it is 0 outside SEND.
- Front buffer is never modified except at the IDLE->LOAD snapshot.

Test Plan:
- Reset, then write pixel2 green=0xA5, commit -> within 2 cycles LOAD starts. Exactly 15 load pulses in order (p0 R,B,G .. p4 R,B,G). The p2 green load carries 0xA5; all others carry 0x00. One send_it follows, then frame_done after LATCH_CYCLES.
- Write pixel 5 (NUM_PIXELS=5) red=0xFF, and wr_color=11 to pixel 0 with 0x33, then commit -> all 15 loaded levels are 0x00.
- During WAIT_TX, write pixel0 red=0x10 and pulse commit twice -> the current frame is unchanged. Exactly one further frame is sent after frame_done, with p0 red=0x10.
- auto_refresh_en=1 with REFRESH_CYCLES=1000 and no commit -> a frame starts every 1000 clocks. Loaded data equals the last committed data; uncommitted back-buffer writes do not appear.
- Hold strand_ready_to_load=0 for 4 cycles mid-LOAD -> load_color is low and indices freeze for those cycles. The sequence resumes at the same pixel/colour with no loads skipped or duplicated.
- Keep strand_ready_to_send=1 after send_it -> tx_error=1 after TX_TIMEOUT clocks, then LATCH and frame_done. Assert reset mid-LOAD -> all outputs 0 asynchronously, state IDLE, tx_error cleared.
